// File: rtl/wrp_master.sv
// -----------------------------------------------------------------------------
// wrp_master
//   Single-transfer AHB bus master that turns a simple client read/write
//   handshake into one SINGLE, word-sized AHB transfer. Each client request
//   is latched, then the block requests the bus, issues one NONSEQ address
//   phase, and waits for the data phase. Completion is reported to the client
//   as a one-cycle MReady pulse, with MError alongside it on an error response.
//
//   Build option:
//     WRP_MASTER_RETRY_EN  defined   : RETRY/SPLIT re-arbitrates and re-issues
//                                      the latched transfer. No MReady is
//                                      produced for the retried attempt.
//                          undefined : RETRY/SPLIT completes with MError.
//
//   Ports
//     HCLK, HRESETn          clock and asynchronous active-low reset
//     MRead, MWrite          client request, held until MReady
//     MAddress, MWriteData   client address and write data
//     MReadData              registered read data (updated on OKAY reads)
//     MReady, MError         one-cycle completion and error pulses
//     HBUSREQ, HLOCK, HGRANT arbitration
//     HTRANS, HWRITE, HSIZE, HBURST, HADDR, HWDATA   AHB master outputs
//     HRDATA, HREADY, HRESP  AHB slave response
// -----------------------------------------------------------------------------
module wrp_master #(
  parameter logic [2:0] HSIZE_CFG = 3'b010
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        MRead,
  input  logic        MWrite,
  input  logic [31:0] MAddress,
  input  logic [31:0] MWriteData,
  output logic [31:0] MReadData,
  output logic        MReady,
  output logic        MError,
  output logic        HBUSREQ,
  output logic        HLOCK,
  input  logic        HGRANT,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ADDR = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  // Client-side latch, captured once when a request is accepted in IDLE.
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  // Bus-side registers, updated only when the address phase is launched so
  // HADDR keeps its last value between transfers.
  logic        r_hwrite;
  logic [31:0] r_haddr;
  logic [31:0] r_hwdata;
  logic [31:0] r_rdata;
  logic        r_mready;
  logic        r_merror;

  logic        w_start;
  logic        w_issue;
  logic        w_ok_done;
  logic        w_err_done;

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    w_ok_done   = 1'b0;
    w_err_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A request still present in the MReady cycle belongs to the
        // transfer that is just finishing, so it must not restart.
        if ((MRead || MWrite) && !r_mready) begin
          w_start     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (HGRANT && HREADY) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (HRESP == RESP_OKAY) begin
          if (HREADY) begin
            w_ok_done   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          // Non-OKAY responses are acted on in their first cycle; the MReady
          // pulse then lines up with the second cycle of the response.
`ifdef WRP_MASTER_RETRY_EN
          if (HRESP[1]) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_err_done  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
`else
          w_err_done  = 1'b1;
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= ST_IDLE;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_hwrite <= 1'b0;
      r_haddr  <= '0;
      r_hwdata <= '0;
      r_rdata  <= '0;
      r_mready <= 1'b0;
      r_merror <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mready <= w_ok_done | w_err_done;
      r_merror <= w_err_done;
      if (w_start) begin
        // Write wins when both request lines are high.
        r_write <= MWrite;
        r_addr  <= MAddress;
        r_wdata <= MWriteData;
      end
      if (w_issue) begin
        r_haddr  <= r_addr;
        r_hwrite <= r_write;
        if (r_write) r_hwdata <= r_wdata;
      end
      if (w_ok_done && !r_write) r_rdata <= HRDATA;
    end
  end

  // Decoded from the state register, so reset forces these low immediately.
  assign HTRANS    = (r_state == ST_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HBUSREQ   = (r_state == ST_REQ);
  assign HLOCK     = 1'b0;
  assign HBURST    = 3'b000;
  assign HSIZE     = HSIZE_CFG;
  assign HADDR     = r_haddr;
  assign HWRITE    = r_hwrite;
  assign HWDATA    = r_hwdata;
  assign MReadData = r_rdata;
  assign MReady    = r_mready;
  assign MError    = r_merror;

endmodule

// File: doc/wrp_master.md
WRP_MASTER -- requirements
Module: wrp_master

Interface
REQ-001 SHALL have parameter: HSIZE_CFG, 3'b010, HSIZE driven on every transfer (word).
REQ-002 SHALL have port: HCLK  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: HRESETn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: MRead, MWrite  in  1 each  client read/write request, held until MReady.
REQ-005 SHALL have ports: MAddress, MWriteData  in  32 each  client address and write data, stable while requesting.
REQ-006 SHALL have ports: MReadData  out  32  registered read data; MReady  out  1  one-cycle completion pulse; MError  out  1  one-cycle error pulse, coincident with MReady.
REQ-007 SHALL have ports: HBUSREQ, HLOCK  out  1 each; HGRANT  in  1.
REQ-008 SHALL have ports: HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HADDR, HWDATA  out  32 each.
REQ-009 SHALL have ports: HRDATA  in  32; HREADY  in  1; HRESP  in  2.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, ADDR, DATA.
REQ-011 IDLE: on MRead|MWrite with MReady=0, latch address, direction and write data, go to REQ; MWrite has priority when both are high.
REQ-012 REQ: HBUSREQ=1; on edge with HGRANT=1 and HREADY=1, go to ADDR.
REQ-013 ADDR: HTRANS=NONSEQ (2'b10), HADDR/HWRITE from latch, HBUSREQ=0; on edge with HREADY=1, go to DATA; otherwise hold all address-phase outputs.
REQ-014 DATA: HTRANS=IDLE, HWDATA=latched data for writes; wait while HREADY=0 and HRESP=OKAY.
REQ-015 DATA, HREADY=1 and HRESP=OKAY: capture HRDATA into MReadData (reads only), pulse MReady next cycle, go to IDLE.
REQ-016 DATA, first cycle of a two-cycle response with HREADY=0 and HRESP=ERROR: pulse MReady and MError on completion, go to IDLE.
REQ-017 HBURST SHALL be SINGLE (3'b000), HLOCK SHALL be 0, and HSIZE SHALL equal HSIZE_CFG at all times.
REQ-018 Outside ADDR, HTRANS SHALL be IDLE (2'b00); HADDR holds its last value.
REQ-019 Minimum latency: request sampled at edge E0, MReady high in the cycle after E3, given zero-wait grant and slave.
REQ-020 Client request changes while the FSM is not in IDLE SHALL be ignored; latched values SHALL be used throughout.
REQ-021 A request present during the MReady cycle SHALL NOT start a new transfer.

Reset
REQ-022 HRESETn low SHALL force IDLE immediately, including mid-transfer.
REQ-023 All outputs SHALL be zero on reset: HTRANS=IDLE, HBUSREQ=0, MReady=0, MError=0, MReadData=0, HADDR=0, HWDATA=0.
REQ-024 No pending transfer SHALL resume after reset release.

Configuration
REQ-025 Macro WRP_MASTER_RETRY_EN defined: RETRY (2'b10) or SPLIT (2'b11) in DATA SHALL return to REQ and re-issue the latched transfer, with no MReady.
REQ-026 Macro WRP_MASTER_RETRY_EN undefined: RETRY or SPLIT SHALL complete like ERROR (MReady=1, MError=1).

Verification
REQ-027 Read, HGRANT=1, zero wait, HRDATA=32'hDEADBEEF at 0x100 -> NONSEQ at 0x100 with HWRITE=0; MReadData=32'hDEADBEEF with MReady in the 4th cycle after the request edge.
REQ-028 Write of 32'h12345678 to 0x200, HGRANT delayed 3 cycles -> HBUSREQ high 3 cycles; HWDATA=32'h12345678 in DATA; single MReady pulse.
REQ-029 Slave inserts 2 wait states, then ERROR response -> HTRANS=IDLE during the waits; MReady=1 and MError=1 on the same cycle.
REQ-030 RETRY response -> with WRP_MASTER_RETRY_EN, HBUSREQ is re-asserted and the second NONSEQ reaches the same address; without it, MError=1.
REQ-031 HRESETn asserted while in DATA -> same cycle HTRANS=IDLE, HBUSREQ=0, no MReady.
REQ-032 MRead and MWrite both high -> HWRITE=1 on the transfer.
